// File: rtl/regfile_write_queue.sv
// regfile_write_queue: small FIFO between the writeback source and the
// register-file write port. Head entry falls through to the decoder/write
// port outputs; flush and reset discard everything queued.
module regfile_write_queue #(
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         wr_req,
   input  logic [AW-1:0]                wr_addr,
   input  logic [DW-1:0]                wr_data,
   output logic                         wr_ready,
   input  logic                         flush,
   input  logic                         stall,
   output logic                         rf_we,
   output logic [AW-1:0]                rf_addr,
   output logic [DW-1:0]                rf_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH+1);

   // Storage is deliberately never reset; occupancy gates visibility.
   logic [AW-1:0] mem_addr [DEPTH];
   logic [DW-1:0] mem_data [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          push_c;
   logic          pop_c;
   logic          not_empty_c;

   // Handshake and pop qualification from registered occupancy only
   always_comb begin
      not_empty_c = (count != CW'(0));
      wr_ready    = (count != CW'(DEPTH));
      push_c      = wr_req && wr_ready && !flush;
      rf_we       = not_empty_c && !stall && !flush;
      pop_c       = rf_we;
   end

   // First-word fall-through of the head entry, zeroed when empty
   always_comb begin
      rf_addr = '0;
      rf_data = '0;
      if (not_empty_c) begin
         rf_addr = mem_addr[head];
         rf_data = mem_data[head];
      end
   end

   // Entry storage written at the tail on every accepted push
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_addr[tail] <= wr_addr;
         mem_data[tail] <= wr_data;
      end
   end

   // Pointers and occupancy; flush overrides any same-cycle push/pop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_c) tail <= tail + PW'(1);
         if (pop_c)  head <= head + PW'(1);
         case ({push_c, pop_c})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue (AW=5, DW=64, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_regfile_write_queue;

   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 64;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH+1);

   logic          clk;
   logic          reset_n;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          flush;
   logic          stall;
   logic          rf_we;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;
   logic [CW-1:0] count;

   int n_chk;
   int n_pass;

   regfile_write_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .flush    (flush),
      .stall    (stall),
      .rf_we    (rf_we),
      .rf_addr  (rf_addr),
      .rf_data  (rf_data),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports mismatches
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [DW-1:0] dat(input int a);
      return 64'h1000 + 64'(a);
   endfunction

   initial begin
      n_chk   = 0;
      n_pass  = 0;
      reset_n = 1'b0;
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      flush   = 1'b0;
      stall   = 1'b0;

      // Reset state
      #2;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_we", 64'(rf_we), 64'd0);
      chk("rst_addr", 64'(rf_addr), 64'd0);
      chk("rst_data", rf_data, 64'd0);
      chk("rst_ready", 64'(wr_ready), 64'd1);

      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Single push, no bypass when empty, then one write
      wr_req = 1'b1; wr_addr = 5'd3; wr_data = 64'hA5;
      settle();
      chk("single_nobypass_we", 64'(rf_we), 64'd0);
      tick();
      wr_req = 1'b0;
      settle();
      chk("single_we", 64'(rf_we), 64'd1);
      chk("single_addr", 64'(rf_addr), 64'd3);
      chk("single_data", rf_data, 64'hA5);
      chk("single_count1", 64'(count), 64'd1);
      tick();
      settle();
      chk("single_count0", 64'(count), 64'd0);
      chk("single_we0", 64'(rf_we), 64'd0);
      chk("single_addr0", 64'(rf_addr), 64'd0);

      // Fill under stall, drop fifth request, drain in order
      stall = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         wr_req = 1'b1; wr_addr = AW'(i); wr_data = dat(i);
         tick();
      end
      wr_addr = 5'd9; wr_data = dat(9);
      settle();
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(wr_ready), 64'd0);
      chk("full_stall_we", 64'(rf_we), 64'd0);
      chk("full_stall_head", 64'(rf_addr), 64'd1);
      tick();
      wr_req = 1'b0; stall = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         settle();
         chk("drain_addr", 64'(rf_addr), 64'(i));
         chk("drain_data", rf_data, dat(i));
         chk("drain_we", 64'(rf_we), 64'd1);
         tick();
      end
      settle();
      chk("drain_count0", 64'(count), 64'd0);
      chk("drain_we0", 64'(rf_we), 64'd0);

      // Full with stall released and wr_req high: pop only
      stall = 1'b1;
      for (int i = 10; i <= 13; i++) begin
         wr_req = 1'b1; wr_addr = AW'(i); wr_data = dat(i);
         tick();
      end
      stall = 1'b0; wr_addr = 5'd14; wr_data = dat(14);
      settle();
      chk("fullpop_ready", 64'(wr_ready), 64'd0);
      chk("fullpop_we", 64'(rf_we), 64'd1);
      chk("fullpop_addr", 64'(rf_addr), 64'd10);
      tick();
      wr_req = 1'b0; stall = 1'b1;
      settle();
      chk("fullpop_count3", 64'(count), 64'd3);
      chk("fullpop_ready1", 64'(wr_ready), 64'd1);
      chk("fullpop_head", 64'(rf_addr), 64'd11);

      // Flush at count 3 with a concurrent push request
      flush = 1'b1; wr_req = 1'b1; wr_addr = 5'd20; stall = 1'b0;
      settle();
      chk("flush_we", 64'(rf_we), 64'd0);
      tick();
      flush = 1'b0; wr_req = 1'b0;
      settle();
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_we_after", 64'(rf_we), 64'd0);
      chk("flush_ready", 64'(wr_ready), 64'd1);
      chk("flush_addr", 64'(rf_addr), 64'd0);

      // Steady push+pop at count 2 across pointer wrap
      stall = 1'b1;
      for (int i = 0; i <= 1; i++) begin
         wr_req = 1'b1; wr_addr = AW'(i); wr_data = dat(i);
         tick();
      end
      stall = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wr_req = 1'b1; wr_addr = AW'(i + 2); wr_data = dat(i + 2);
         settle();
         chk("stream_addr", 64'(rf_addr), 64'(i));
         chk("stream_data", rf_data, dat(i));
         chk("stream_count", 64'(count), 64'd2);
         tick();
      end
      wr_req = 1'b0;
      settle();
      chk("stream_tail0", 64'(rf_addr), 64'd10);
      tick();
      settle();
      chk("stream_tail1", 64'(rf_addr), 64'd11);
      tick();
      settle();
      chk("stream_empty", 64'(count), 64'd0);

      // Asynchronous reset between edges at count 2
      stall = 1'b1;
      for (int i = 7; i <= 8; i++) begin
         wr_req = 1'b1; wr_addr = AW'(i); wr_data = dat(i);
         tick();
      end
      wr_req = 1'b0;
      #2;
      stall = 1'b0; reset_n = 1'b0;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_we", 64'(rf_we), 64'd0);
      chk("arst_addr", 64'(rf_addr), 64'd0);
      chk("arst_data", rf_data, 64'd0);
      chk("arst_ready", 64'(wr_ready), 64'd1);
      tick();
      reset_n = 1'b1;
      settle();
      chk("arst_post_we", 64'(rf_we), 64'd0);
      tick();
      chk("arst_post_we2", 64'(rf_we), 64'd0);
      chk("arst_post_count", 64'(count), 64'd0);
      wr_req = 1'b1; wr_addr = 5'd5; wr_data = dat(5);
      tick();
      wr_req = 1'b0;
      settle();
      chk("arst_new_we", 64'(rf_we), 64'd1);
      chk("arst_new_addr", 64'(rf_addr), 64'd5);
      chk("arst_new_data", rf_data, dat(5));
      tick();
      chk("arst_new_empty", 64'(count), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
